enemy_hitbox_array: RTL and testbench

//  Parametrised N-channel hitbox unit for the enemy layer.
//  - Draws a padded collision bracket around each live enemy.
//  - Accumulates per-frame player/enemy overlaps.
//  - Reports one hit record per frame to game control via a valid/ack handshake.
//  - Sits between the enemy movement blocks and the VGA object mux / game-control FSM.

---
 rtl/enemy_hitbox_array.sv | 145 ++++++++++++++
 tb/tb_enemy_hitbox_array.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/enemy_hitbox_array.sv
// N-channel enemy hitbox: padded bracket drawing from frame-latched positions,
// per-frame player overlap accumulation, and a valid/ack hit report per frame.
module enemy_hitbox_array #(
  parameter int          NUM_ENEMIES  = 4,
  parameter int          HITBOX_W     = 20,
  parameter int          HITBOX_H     = 20,
  parameter int          OFFSET_X     = 5,
  parameter int          OFFSET_Y     = 10,
  parameter logic [7:0]  OBJECT_COLOR = 8'h5B,
  localparam int         IDX_W        = (NUM_ENEMIES > 1) ? $clog2(NUM_ENEMIES) : 1
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [10:0]                 pixelX,
  input  logic [10:0]                 pixelY,
  input  logic [11*NUM_ENEMIES-1:0]   enemyX,
  input  logic [11*NUM_ENEMIES-1:0]   enemyY,
  input  logic [NUM_ENEMIES-1:0]      enemyAlive,
  input  logic                        playerDR,
  input  logic                        hitAck,
  output logic                        hitboxDR,
  output logic [7:0]                  RGBout,
  output logic                        hitValid,
  output logic [NUM_ENEMIES-1:0]      hitMask,
  output logic [IDX_W-1:0]            hitIndex,
  output logic                        hitOverrun
);

  localparam logic [0:0] ACCUM  = 1'b0;
  localparam logic [0:0] REPORT = 1'b1;

  localparam logic signed [11:0] OFF_X  = 12'(OFFSET_X);
  localparam logic signed [11:0] SPAN_X = 12'(HITBOX_W + OFFSET_X);
  localparam logic signed [11:0] OFF_Y  = 12'(OFFSET_Y);
  localparam logic signed [11:0] BOX_H  = 12'(HITBOX_H);

  logic [NUM_ENEMIES-1:0][10:0] x_q, x_d, y_q, y_d;
  logic [NUM_ENEMIES-1:0]       alive_q, alive_d;
  logic [NUM_ENEMIES-1:0]       frame_hits_q, frame_hits_d;
  logic [NUM_ENEMIES-1:0]       hit_mask_q, hit_mask_d;
  logic [IDX_W-1:0]             hit_idx_q, hit_idx_d;
  logic [0:0]                   state_q, state_d;
  logic                         draw_q, draw_d;
  logic                         ovr_q, ovr_d;

  logic [NUM_ENEMIES-1:0]       in_vec;
  logic [NUM_ENEMIES-1:0]       overlap;
  logic [IDX_W-1:0]             low_idx;
  logic                         new_rec;
  logic signed [11:0]           px_s, py_s, l_s, r_s, t_s, b_s;

  // Positions only move on frame boundaries so a bracket never tears mid-frame.
  always_comb begin
    x_d     = startOfFrame ? enemyX     : x_q;
    y_d     = startOfFrame ? enemyY     : y_q;
    alive_d = startOfFrame ? enemyAlive : alive_q;
  end

  always_comb begin
    px_s   = $signed({1'b0, pixelX});
    py_s   = $signed({1'b0, pixelY});
    l_s    = '0;
    r_s    = '0;
    t_s    = '0;
    b_s    = '0;
    in_vec = '0;
    for (int i = 0; i < NUM_ENEMIES; i++) begin
      l_s       = $signed({1'b0, x_q[i]}) - OFF_X;
      r_s       = $signed({1'b0, x_q[i]}) + SPAN_X;
      t_s       = $signed({1'b0, y_q[i]}) + OFF_Y;
      b_s       = t_s + BOX_H;
      in_vec[i] = alive_q[i] && (px_s >= l_s) && (px_s < r_s) &&
                  (py_s >= t_s) && (py_s < b_s);
    end
  end

  always_comb begin
    overlap      = in_vec & {NUM_ENEMIES{playerDR}};
    frame_hits_d = startOfFrame ? overlap : (frame_hits_q | overlap);
    draw_d       = |in_vec;
    low_idx      = '0;
    for (int i = NUM_ENEMIES - 1; i >= 0; i--) begin
      if (frame_hits_q[i]) low_idx = IDX_W'(i);
    end
  end

  // Record handoff: ack+SOF consumes and reloads in one cycle, unacked SOF merges.
  always_comb begin
    state_d    = state_q;
    hit_mask_d = hit_mask_q;
    hit_idx_d  = hit_idx_q;
    ovr_d      = ovr_q;
    new_rec    = startOfFrame && (|frame_hits_q);
    if (state_q == ACCUM) begin
      if (new_rec) begin
        state_d    = REPORT;
        hit_mask_d = frame_hits_q;
        hit_idx_d  = low_idx;
      end
    end else if (hitAck) begin
      if (new_rec) begin
        hit_mask_d = frame_hits_q;
        hit_idx_d  = low_idx;
      end else begin
        state_d = ACCUM;
      end
    end else if (new_rec) begin
      hit_mask_d = hit_mask_q | frame_hits_q;
      ovr_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      x_q          <= '0;
      y_q          <= '0;
      alive_q      <= '0;
      frame_hits_q <= '0;
      hit_mask_q   <= '0;
      hit_idx_q    <= '0;
      state_q      <= ACCUM;
      draw_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      alive_q      <= alive_d;
      frame_hits_q <= frame_hits_d;
      hit_mask_q   <= hit_mask_d;
      hit_idx_q    <= hit_idx_d;
      state_q      <= state_d;
      draw_q       <= draw_d;
      ovr_q        <= ovr_d;
    end
  end

  assign hitboxDR   = draw_q;
  assign RGBout     = OBJECT_COLOR;
  assign hitValid   = (state_q == REPORT);
  assign hitMask    = hit_mask_q;
  assign hitIndex   = hit_idx_q;
  assign hitOverrun = ovr_q;

endmodule

// File: tb/tb_enemy_hitbox_array.sv
// Directed bench for enemy_hitbox_array: draw expectations and hit records are
// queued when stimulus is driven and compared one cycle later.
module tb_enemy_hitbox_array;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            resetN;
  logic            startOfFrame;
  logic [10:0]     pixelX, pixelY;
  logic [11*N-1:0] enemyX, enemyY;
  logic [N-1:0]    enemyAlive;
  logic            playerDR, hitAck;
  logic            hitboxDR;
  logic [7:0]      RGBout;
  logic            hitValid;
  logic [N-1:0]    hitMask;
  logic [1:0]      hitIndex;
  logic            hitOverrun;

  typedef struct packed {
    logic         v;
    logic [N-1:0] m;
    logic [1:0]   i;
    logic         o;
  } rec_t;

  bit   draw_q[$];
  rec_t rec_q[$];
  int   sh_x[N], sh_y[N];
  bit   sh_alive[N];
  int   nvec = 0;
  int   nerr = 0;

  enemy_hitbox_array dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .enemyX(enemyX), .enemyY(enemyY),
    .enemyAlive(enemyAlive), .playerDR(playerDR), .hitAck(hitAck),
    .hitboxDR(hitboxDR), .RGBout(RGBout), .hitValid(hitValid),
    .hitMask(hitMask), .hitIndex(hitIndex), .hitOverrun(hitOverrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_model(input int c, input int px, input int py);
    int l, r, t, b;
    l = sh_x[c] - 5;
    r = sh_x[c] + 20 + 5;
    t = sh_y[c] + 10;
    b = t + 20;
    return sh_alive[c] && px >= l && px < r && py >= t && py < b;
  endfunction

  task automatic set_enemy(input int c, input int x, input int y, input bit alive);
    enemyX[11*c +: 11] = 11'(x);
    enemyY[11*c +: 11] = 11'(y);
    enemyAlive[c]      = alive;
  endtask

  task automatic push_rec(input bit v, input logic [N-1:0] m, input logic [1:0] i, input bit o);
    rec_t r;
    r.v = v; r.m = m; r.i = i; r.o = o;
    rec_q.push_back(r);
  endtask

  task automatic step(input bit sof, input int px, input int py, input bit pdr, input bit ack);
    bit   e;
    rec_t r;
    @(negedge clk);
    if (draw_q.size() > 0) begin
      e = draw_q.pop_front();
      chk("hitboxDR", 32'(hitboxDR), 32'(e));
    end
    if (rec_q.size() > 0) begin
      r = rec_q.pop_front();
      chk("hitValid",   32'(hitValid),   32'(r.v));
      chk("hitMask",    32'(hitMask),    32'(r.m));
      chk("hitIndex",   32'(hitIndex),   32'(r.i));
      chk("hitOverrun", 32'(hitOverrun), 32'(r.o));
    end
    startOfFrame = sof;
    pixelX       = 11'(px);
    pixelY       = 11'(py);
    playerDR     = pdr;
    hitAck       = ack;
    e = 1'b0;
    for (int c = 0; c < N; c++) e |= in_model(c, px, py);
    draw_q.push_back(e);
    if (sof) begin
      for (int c = 0; c < N; c++) begin
        sh_x[c]     = int'(enemyX[11*c +: 11]);
        sh_y[c]     = int'(enemyY[11*c +: 11]);
        sh_alive[c] = enemyAlive[c];
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hitboxDR"},   32'(hitboxDR),   32'd0);
    chk({tag, "_hitValid"},   32'(hitValid),   32'd0);
    chk({tag, "_hitMask"},    32'(hitMask),    32'd0);
    chk({tag, "_hitIndex"},   32'(hitIndex),   32'd0);
    chk({tag, "_hitOverrun"}, 32'(hitOverrun), 32'd0);
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; pixelX = '0; pixelY = '0;
    enemyX = '0; enemyY = '0; enemyAlive = '0; playerDR = 1'b0; hitAck = 1'b0;
    for (int c = 0; c < N; c++) begin sh_x[c] = 0; sh_y[c] = 0; sh_alive[c] = 1'b0; end
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    chk("RGBout", 32'(RGBout), 32'h5B);
    resetN = 1'b1;

    // 1: bracket geometry and shadow latching
    set_enemy(0, 100, 50, 1); set_enemy(1, 300, 100, 1);
    set_enemy(2, 500, 200, 1); set_enemy(3, 700, 300, 1);
    step(1, 0, 0, 0, 0);
    step(0, 94, 70, 0, 0);  step(0, 95, 70, 0, 0);
    step(0, 124, 70, 0, 0); step(0, 125, 70, 0, 0);
    step(0, 110, 59, 0, 0); step(0, 110, 60, 0, 0);
    step(0, 110, 79, 0, 0); step(0, 110, 80, 0, 0);
    set_enemy(0, 400, 50, 1);
    step(0, 100, 70, 0, 0);
    set_enemy(0, 100, 50, 1);

    // 2: single hit, report, ack
    step(0, 110, 70, 1, 0);
    step(1, 0, 0, 0, 0);    push_rec(1, 4'b0001, 2'd0, 1'b0);
    step(0, 0, 0, 0, 1);    push_rec(0, 4'b0001, 2'd0, 1'b0);
    step(0, 0, 0, 0, 0);

    // 3: two channels in one frame
    step(0, 310, 120, 1, 0); step(0, 710, 320, 1, 0);
    step(1, 0, 0, 0, 0);    push_rec(1, 4'b1010, 2'd1, 1'b0);
    step(0, 0, 0, 0, 1);    push_rec(0, 4'b1010, 2'd1, 1'b0);
    step(0, 0, 0, 0, 0);

    // 4: unacked record merges the next frame and flags overrun
    step(0, 310, 120, 1, 0); step(0, 710, 320, 1, 0);
    step(1, 0, 0, 0, 0);    push_rec(1, 4'b1010, 2'd1, 1'b0);
    step(0, 510, 220, 1, 0);
    step(1, 0, 0, 0, 0);    push_rec(1, 4'b1110, 2'd1, 1'b1);
    step(0, 0, 0, 0, 1);    push_rec(0, 4'b1110, 2'd1, 1'b1);
    step(0, 0, 0, 0, 1);    push_rec(0, 4'b1110, 2'd1, 1'b1);
    step(0, 0, 0, 0, 0);

    // 5: negative left edge, no wrap, dead channel
    set_enemy(0, 2, 50, 1);
    step(1, 0, 0, 0, 0);    push_rec(0, 4'b1110, 2'd1, 1'b1);
    step(0, 0, 70, 0, 0);   step(0, 2045, 70, 0, 0);
    step(0, 26, 70, 0, 0);  step(0, 27, 70, 0, 0);
    set_enemy(0, 2, 50, 0);
    step(1, 0, 0, 0, 0);
    step(0, 10, 70, 1, 0);
    step(1, 0, 0, 0, 0);    push_rec(0, 4'b1110, 2'd1, 1'b1);

    // 6: ack coincident with SOF, all-channel hit, async reset
    set_enemy(0, 100, 50, 1);
    step(1, 0, 0, 0, 0);
    step(0, 110, 70, 1, 0);
    step(1, 0, 0, 0, 0);    push_rec(1, 4'b0001, 2'd0, 1'b1);
    step(0, 710, 320, 1, 0);
    step(1, 0, 0, 0, 1);    push_rec(1, 4'b1000, 2'd3, 1'b1);
    step(0, 0, 0, 0, 0);    push_rec(1, 4'b1000, 2'd3, 1'b1);
    step(1, 0, 0, 0, 1);    push_rec(0, 4'b1000, 2'd3, 1'b1);
    step(0, 110, 70, 1, 0); step(0, 310, 120, 1, 0);
    step(0, 510, 220, 1, 0); step(0, 710, 320, 1, 0);
    step(1, 0, 0, 0, 0);    push_rec(1, 4'b1111, 2'd0, 1'b1);
    step(0, 0, 0, 0, 0);    push_rec(1, 4'b1111, 2'd0, 1'b1);
    step(0, 110, 70, 1, 0);

    #2 resetN = 1'b0;
    #1 chk_all_zero("async_rst");
    draw_q.delete();
    rec_q.delete();
    for (int c = 0; c < N; c++) begin sh_x[c] = 0; sh_y[c] = 0; sh_alive[c] = 1'b0; end
    @(negedge clk);
    chk_all_zero("held_rst");
    resetN = 1'b1;
    step(0, 110, 70, 1, 0);
    step(1, 0, 0, 0, 0);    push_rec(0, 4'b0000, 2'd0, 1'b0);
    step(0, 110, 70, 0, 0);
    step(0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
